// File: rtl/fwd_arb_pkg.sv
// Shared types and helpers for the forwarder arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM states (IDLE, OFFER, BUSY)
//   sel_w()     : width of a core index for a given core count (minimum 1)
package fwd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req  : one request bit per core
//   last : index of the most recently served core
//   pick : first requesting core searching upward from last+1, wrapping modulo N_CORES
//   any  : at least one request is set
module rr_picker
    import fwd_arb_pkg::*;
#(
    parameter int unsigned  N_CORES = 4,
    localparam int unsigned SEL_W   = sel_w(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = '0;
        for (int unsigned k = N_CORES; k > 0; k--) begin
            idx = (32'(last) + k) % N_CORES;
            if (req[SEL_W'(idx)]) begin
                pick = SEL_W'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fwd_arbiter.sv
// Shares one downstream forwarder among N_CORES packetfilter cores.
// A round-robin pick among ready cores is offered to the forwarder; once the
// forwarder accepts, its reads are routed to that core and the done handshake
// is relayed back, after which the next core is picked.
//   clk, rst                      : clock, async active-high reset
//   fwd_*, rdy_for_fwd*           : forwarder-side agent interface
//   core_*                        : packed per-core agent interfaces (core i at slice i)
//   grant_sel                     : current/last granted core (debug)
module fwd_arbiter
    import fwd_arb_pkg::*;
#(
    parameter int unsigned  N_CORES           = 4,
    parameter int unsigned  SN_FWD_ADDR_WIDTH = 9,
    parameter int unsigned  SN_FWD_DATA_WIDTH = 64,
    parameter int unsigned  PLEN_WIDTH        = 32,
    parameter int unsigned  OUT_REG           = 0,
    localparam int unsigned SEL_W             = sel_w(N_CORES)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // forwarder side
    input  logic [SN_FWD_ADDR_WIDTH-1:0]           fwd_addr,
    input  logic                                   fwd_rd_en,
    output logic [SN_FWD_DATA_WIDTH-1:0]           fwd_rd_data,
    output logic                                   fwd_rd_data_vld,
    output logic [PLEN_WIDTH-1:0]                  fwd_byte_len,
    input  logic                                   fwd_done,
    output logic                                   fwd_done_ack,
    output logic                                   rdy_for_fwd,
    input  logic                                   rdy_for_fwd_ack,
    // core side
    output logic [SN_FWD_ADDR_WIDTH-1:0]           core_fwd_addr,
    output logic [N_CORES-1:0]                     core_fwd_rd_en,
    input  logic [N_CORES*SN_FWD_DATA_WIDTH-1:0]   core_fwd_rd_data,
    input  logic [N_CORES-1:0]                     core_fwd_rd_data_vld,
    input  logic [N_CORES*PLEN_WIDTH-1:0]          core_fwd_byte_len,
    output logic [N_CORES-1:0]                     core_fwd_done,
    input  logic [N_CORES-1:0]                     core_fwd_done_ack,
    input  logic [N_CORES-1:0]                     core_rdy_for_fwd,
    output logic [N_CORES-1:0]                     core_rdy_for_fwd_ack,
    output logic [SEL_W-1:0]                       grant_sel
);

    arb_state_e state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic [SEL_W-1:0] pick;
    logic             any_rdy;
    logic [N_CORES-1:0] sel_oh;

    logic                         sel_rdy;
    logic                         sel_vld;
    logic                         sel_done_ack;
    logic [SN_FWD_DATA_WIDTH-1:0] sel_data;
    logic [PLEN_WIDTH-1:0]        sel_len;

    logic [SN_FWD_DATA_WIDTH-1:0] rd_data_d;
    logic                         rd_data_vld_d;
    logic [PLEN_WIDTH-1:0]        byte_len_d;

    rr_picker #(
        .N_CORES (N_CORES)
    ) u_picker (
        .req  (core_rdy_for_fwd),
        .last (last_q),
        .pick (pick),
        .any  (any_rdy)
    );

    assign sel_oh    = N_CORES'(1) << sel_q;
    assign grant_sel = sel_q;

    // Slice mux for the selected core; constant indices only, so a non power-of-2
    // core count never produces an out-of-range select.
    always_comb begin
        sel_rdy      = 1'b0;
        sel_vld      = 1'b0;
        sel_done_ack = 1'b0;
        sel_data     = '0;
        sel_len      = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_rdy      = core_rdy_for_fwd[i];
                sel_vld      = core_fwd_rd_data_vld[i];
                sel_done_ack = core_fwd_done_ack[i];
                sel_data     = core_fwd_rd_data[i*SN_FWD_DATA_WIDTH +: SN_FWD_DATA_WIDTH];
                sel_len      = core_fwd_byte_len[i*PLEN_WIDTH +: PLEN_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_CORES - 1);  // core 0 wins the first pick
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_rdy) begin
                    sel_d   = pick;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // A withdrawn offer goes back to IDLE without touching last.
                if (sel_rdy && rdy_for_fwd_ack) begin
                    state_d = ST_BUSY;
                end else if (!sel_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (sel_done_ack) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshakes pass through combinationally; everything is quiet in IDLE.
    always_comb begin
        rdy_for_fwd          = 1'b0;
        core_rdy_for_fwd_ack = '0;
        core_fwd_rd_en       = '0;
        core_fwd_done        = '0;
        core_fwd_addr        = '0;
        fwd_done_ack         = 1'b0;
        rd_data_d            = '0;
        rd_data_vld_d        = 1'b0;
        byte_len_d           = '0;
        case (state_q)
            ST_OFFER: begin
                rdy_for_fwd = sel_rdy;
                if (sel_rdy && rdy_for_fwd_ack) begin
                    core_rdy_for_fwd_ack = sel_oh;
                end
                rd_data_d  = sel_data;
                byte_len_d = sel_len;
            end
            ST_BUSY: begin
                // Address only matters to the granted core, so it is driven only here.
                core_fwd_addr = fwd_addr;
                if (fwd_rd_en) begin
                    core_fwd_rd_en = sel_oh;
                end
                if (fwd_done) begin
                    core_fwd_done = sel_oh;
                end
                fwd_done_ack  = sel_done_ack;
                rd_data_d     = sel_data;
                rd_data_vld_d = sel_vld;
                byte_len_d    = sel_len;
            end
            default: ;
        endcase
    end

    // Optional output stage toward the forwarder
    if (OUT_REG != 0) begin : g_out_reg
        logic [SN_FWD_DATA_WIDTH-1:0] rd_data_q;
        logic                         rd_data_vld_q;
        logic [PLEN_WIDTH-1:0]        byte_len_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q     <= '0;
                rd_data_vld_q <= 1'b0;
                byte_len_q    <= '0;
            end else begin
                rd_data_q     <= rd_data_d;
                rd_data_vld_q <= rd_data_vld_d;
                byte_len_q    <= byte_len_d;
            end
        end

        assign fwd_rd_data     = rd_data_q;
        assign fwd_rd_data_vld = rd_data_vld_q;
        assign fwd_byte_len    = byte_len_q;
    end else begin : g_out_comb
        assign fwd_rd_data     = rd_data_d;
        assign fwd_rd_data_vld = rd_data_vld_d;
        assign fwd_byte_len    = byte_len_d;
    end

endmodule

// File: tb/tb_fwd_arbiter.sv
// Bench for fwd_arbiter: directed scenarios plus randomized transactions, with a
// transaction-level model of grant/offer/busy and a per-cycle output compare.
module tb_fwd_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 32;

    logic clk = 1'b0;
    logic rst;

    logic [AW-1:0]   fwd_addr;
    logic            fwd_rd_en;
    logic [DW-1:0]   fwd_rd_data;
    logic            fwd_rd_data_vld;
    logic [LW-1:0]   fwd_byte_len;
    logic            fwd_done;
    logic            fwd_done_ack;
    logic            rdy_for_fwd;
    logic            rdy_ack;
    logic [AW-1:0]   core_fwd_addr;
    logic [N-1:0]    core_fwd_rd_en;
    logic [N*DW-1:0] core_fwd_rd_data;
    logic [N-1:0]    core_fwd_rd_data_vld;
    logic [N*LW-1:0] core_fwd_byte_len;
    logic [N-1:0]    core_fwd_done;
    logic [N-1:0]    core_done_ack;
    logic [N-1:0]    core_rdy;
    logic [N-1:0]    core_rdy_for_fwd_ack;
    logic [SW-1:0]   grant_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_arbiter #(
        .N_CORES           (N),
        .SN_FWD_ADDR_WIDTH (AW),
        .SN_FWD_DATA_WIDTH (DW),
        .PLEN_WIDTH        (LW),
        .OUT_REG           (0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fwd_addr             (fwd_addr),
        .fwd_rd_en            (fwd_rd_en),
        .fwd_rd_data          (fwd_rd_data),
        .fwd_rd_data_vld      (fwd_rd_data_vld),
        .fwd_byte_len         (fwd_byte_len),
        .fwd_done             (fwd_done),
        .fwd_done_ack         (fwd_done_ack),
        .rdy_for_fwd          (rdy_for_fwd),
        .rdy_for_fwd_ack      (rdy_ack),
        .core_fwd_addr        (core_fwd_addr),
        .core_fwd_rd_en       (core_fwd_rd_en),
        .core_fwd_rd_data     (core_fwd_rd_data),
        .core_fwd_rd_data_vld (core_fwd_rd_data_vld),
        .core_fwd_byte_len    (core_fwd_byte_len),
        .core_fwd_done        (core_fwd_done),
        .core_fwd_done_ack    (core_done_ack),
        .core_rdy_for_fwd     (core_rdy),
        .core_rdy_for_fwd_ack (core_rdy_for_fwd_ack),
        .grant_sel            (grant_sel)
    );

    // ---------------- core responders (1-cycle read latency) ----------------
    function automatic logic [DW-1:0] core_word(input logic [SW-1:0] c, input logic [AW-1:0] a);
        return {16'hC0DE, 14'd0, c, 23'd0, a};
    endfunction

    function automatic logic [LW-1:0] blen(input logic [SW-1:0] c);
        return LW'(64 + 17 * int'(c));
    endfunction

    logic [DW-1:0] cdata [N];
    logic [N-1:0]  cvld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cvld <= '0;
            for (int i = 0; i < N; i++) cdata[i] <= '0;
        end else begin
            cvld <= core_fwd_rd_en;
            for (int i = 0; i < N; i++) begin
                if (core_fwd_rd_en[i]) cdata[i] <= core_word(SW'(i), core_fwd_addr);
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_core
        assign core_fwd_rd_data[g*DW +: DW] = cdata[g];
        assign core_fwd_byte_len[g*LW +: LW] = blen(SW'(g));
    end
    assign core_fwd_rd_data_vld = cvld;

    // ---------------- reference model ----------------
    int            m_phase;   // 0 nothing granted, 1 offering m_sel, 2 m_sel owns the forwarder
    logic [SW-1:0] m_sel;
    logic [SW-1:0] m_last;
    logic [SW-1:0] grants[$];
    logic [DW-1:0] rdq[$];

    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] req, input logic [SW-1:0] last);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (req[SW'(c)]) return SW'(c);
        end
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_sel   <= '0;
            m_last  <= SW'(N - 1);
            rdq.delete();
        end else begin
            case (m_phase)
                0: if (core_rdy != '0) begin
                    m_sel   <= rr_pick(core_rdy, m_last);
                    m_phase <= 1;
                end
                1: if (core_rdy[m_sel] && rdy_ack) begin
                    m_phase <= 2;
                    grants.push_back(m_sel);
                end else if (!core_rdy[m_sel]) begin
                    m_phase <= 0;
                end
                default: begin
                    if (fwd_rd_en) rdq.push_back(core_word(m_sel, fwd_addr));
                    if (core_done_ack[m_sel]) begin
                        m_last  <= m_sel;
                        m_phase <= 0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin : cmp
        logic [N-1:0] oh;
        logic offer, busy, r;
        logic [DW-1:0] w;
        if (!rst) begin
            oh    = N'(1) << m_sel;
            offer = (m_phase == 1);
            busy  = (m_phase == 2);
            r     = core_rdy[m_sel];
            chk("rdy_for_fwd", 64'(rdy_for_fwd), 64'(offer & r));
            chk("core_rdy_ack", 64'(core_rdy_for_fwd_ack), (offer & r & rdy_ack) ? 64'(oh) : 64'd0);
            chk("core_rd_en", 64'(core_fwd_rd_en), (busy & fwd_rd_en) ? 64'(oh) : 64'd0);
            chk("core_done", 64'(core_fwd_done), (busy & fwd_done) ? 64'(oh) : 64'd0);
            chk("fwd_done_ack", 64'(fwd_done_ack), 64'(busy & core_done_ack[m_sel]));
            chk("grant_sel", 64'(grant_sel), 64'(m_sel));
            chk("byte_len", 64'(fwd_byte_len), (m_phase != 0) ? 64'(blen(m_sel)) : 64'd0);
            chk("rd_data_route", fwd_rd_data, (m_phase != 0) ? cdata[m_sel] : 64'd0);
            chk("rd_data_vld", 64'(fwd_rd_data_vld), 64'(busy & cvld[m_sel]));
            if (busy) chk("core_addr", 64'(core_fwd_addr), 64'(fwd_addr));
            if (fwd_rd_data_vld) begin
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 64'(fwd_rd_data_vld), 64'd0);
                end else begin
                    w = rdq.pop_front();
                    chk("rd_word", fwd_rd_data, w);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_and_ack(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            if (rdy_for_fwd) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            fail_bound("offer");
        end else begin
            rdy_ack = 1'b1;
            tick();
            rdy_ack = 1'b0;
        end
    endtask

    task automatic run_busy(input int nreads, input int dly);
        int idx;
        for (int k = 0; k < nreads; k++) begin
            fwd_addr  = AW'($urandom_range(0, 511));
            fwd_rd_en = 1'b1;
            tick();
            fwd_rd_en = 1'b0;
            tick();
        end
        fwd_done = 1'b1;
        #1;
        repeat (dly) tick();
        idx = -1;
        for (int i = 0; i < N; i++) if (core_fwd_done[i]) idx = i;
        if (idx < 0) begin
            fail_bound("core_done");
            fwd_done = 1'b0;
        end else begin
            core_done_ack = N'(1) << idx;
            #1;
            chk("done_ack_pulse", 64'(fwd_done_ack), 64'd1);
            tick();
            core_done_ack = '0;
            fwd_done      = 1'b0;
            chk("idle_after_ack", 64'(rdy_for_fwd), 64'd0);
        end
    endtask

    task automatic do_reset();
        core_rdy = '0; rdy_ack = 1'b0; fwd_rd_en = 1'b0; fwd_done = 1'b0; core_done_ack = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},     64'(rdy_for_fwd), 64'd0);
        chk({tag, "_data"},    fwd_rd_data, 64'd0);
        chk({tag, "_vld"},     64'(fwd_rd_data_vld), 64'd0);
        chk({tag, "_len"},     64'(fwd_byte_len), 64'd0);
        chk({tag, "_dack"},    64'(fwd_done_ack), 64'd0);
        chk({tag, "_rd_en"},   64'(core_fwd_rd_en), 64'd0);
        chk({tag, "_done"},    64'(core_fwd_done), 64'd0);
        chk({tag, "_rack"},    64'(core_rdy_for_fwd_ack), 64'd0);
        chk({tag, "_addr"},    64'(core_fwd_addr), 64'd0);
        chk({tag, "_sel"},     64'(grant_sel), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [N-1:0] ackbits;
        rst = 1'b1;
        fwd_addr = '0; fwd_rd_en = 1'b0; fwd_done = 1'b0; rdy_ack = 1'b0;
        core_done_ack = '0; core_rdy = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Stray forwarder inputs with no core ready
        for (int c = 0; c < 4; c++) begin
            rdy_ack = 1'b1; fwd_rd_en = 1'b1; fwd_done = 1'b1; fwd_addr = AW'(c + 3);
            #1;
            chk("stray_rd_en", 64'(core_fwd_rd_en), 64'd0);
            chk("stray_dack", 64'(fwd_done_ack), 64'd0);
            chk("stray_rack", 64'(core_rdy_for_fwd_ack), 64'd0);
            tick();
        end
        rdy_ack = 1'b0; fwd_rd_en = 1'b0; fwd_done = 1'b0;
        tick();

        // Single core 2
        core_rdy = 4'b0100;
        #1;
        chk("offer_lat0", 64'(rdy_for_fwd), 64'd0);
        tick();
        chk("offer_lat1", 64'(rdy_for_fwd), 64'd1);
        chk("single_sel", 64'(grant_sel), 64'd2);
        chk("single_len", 64'(fwd_byte_len), 64'd98);
        tick(); tick();
        rdy_ack = 1'b1;
        #1;
        chk("single_rack", 64'(core_rdy_for_fwd_ack), 64'b0100);
        tick();
        rdy_ack = 1'b0; core_rdy = '0;
        for (int k = 0; k < 4; k++) begin
            fwd_addr = AW'(k); fwd_rd_en = 1'b1;
            #1;
            chk("single_rd_en", 64'(core_fwd_rd_en), 64'b0100);
            tick();
            fwd_rd_en = 1'b0;
            if (k == 1) chk("single_word", fwd_rd_data, 64'hC0DE_0002_0000_0001);
            tick();
        end
        run_busy(0, 3);

        // Fair rotation, all cores ready
        do_reset();
        grants.delete();
        core_rdy = '1;
        for (int t = 0; t < 8; t++) begin
            offer_and_ack(ok);
            if (ok) run_busy(1, 1);
        end
        chk("rot_count", 64'(grants.size()), 64'd8);
        for (int t = 0; t < 8 && t < grants.size(); t++) chk("rot_order", 64'(grants[t]), 64'(t % 4));

        // Ready withdrawn in OFFER
        do_reset();
        grants.delete();
        core_rdy = 4'b1010;
        tick();
        chk("wd_sel1", 64'(grant_sel), 64'd1);
        core_rdy = 4'b1000;
        #1;
        chk("wd_drop", 64'(rdy_for_fwd), 64'd0);
        tick(); tick();
        chk("wd_offer3", 64'(rdy_for_fwd), 64'd1);
        chk("wd_sel3", 64'(grant_sel), 64'd3);
        offer_and_ack(ok);
        if (ok) run_busy(1, 0);
        chk("wd_grant", (grants.size() == 1) ? 64'(grants[0]) : 64'hFFFF, 64'd3);

        // Reset in the middle of BUSY
        core_rdy = 4'b0010;
        offer_and_ack(ok);
        core_rdy = '0;
        fwd_rd_en = 1'b1; fwd_addr = AW'(5); fwd_done = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        fwd_rd_en = 1'b0; fwd_done = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        tick();
        grants.delete();
        core_rdy = '1;
        offer_and_ack(ok);
        chk("post_rst_grant", (grants.size() > 0) ? 64'(grants[0]) : 64'hFFFF, 64'd0);
        if (ok) run_busy(0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            core_rdy = N'($urandom_range(1, 15));
            ok = 1'b0;
            for (int c = 0; c < 60 && !ok; c++) begin
                if (rdy_for_fwd && $urandom_range(0, 3) != 0) begin
                    rdy_ack = 1'b1;
                    #1;
                    ackbits = core_rdy_for_fwd_ack;
                    tick();
                    rdy_ack = 1'b0;
                    if ($urandom_range(0, 1) == 1) core_rdy = core_rdy & ~ackbits;
                    ok = 1'b1;
                end else begin
                    if ($urandom_range(0, 2) == 0) core_rdy = N'($urandom_range(1, 15));
                    tick();
                end
            end
            if (!ok) fail_bound("rand_offer");
            else run_busy($urandom_range(0, 3), $urandom_range(0, 3));
        end
        core_rdy = '0;
        repeat (3) tick();
        chk("rdq_empty", 64'(rdq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
